// File: rtl/gan_sched_pkg.sv
// Shared definitions for the GAN inference scheduler.
// Contents: scheduler FSM state type, Q1.15 constants, image geometry,
// and a saturating 16-bit increment used by the delivery counters.
package gan_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } sched_state_t;

    localparam logic signed [15:0] Q15_HALF = 16'sh4000;
    localparam int PIX_W   = 16;
    localparam int NUM_PIX = 9;
    localparam int IMG_W   = PIX_W * NUM_PIX;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gan_noise_fifo.sv
// Synchronous FIFO with a registered occupancy count.
// Ports: clk, rst (sync, active-high); push/push_data write side;
// pop/head read side (head is the oldest entry, valid when !empty);
// full/empty derived from the registered count only.
module gan_noise_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage array; validity is tracked by the count, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/gan_infer_scheduler.sv
// Request scheduler in front of simple_gan_top: queues noise pairs, runs
// one inference at a time via core_start/core_done, and returns each
// result with a sequence tag, REAL flag and watchdog-timeout flag.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_noise_* request
// side; core_start/core_noise_* to the core, core_done/core_image/core_prob
// from it; out_valid/out_ready/out_* result side; busy; sample_count and
// real_count saturating delivery counters.
module gan_infer_scheduler
    import gan_sched_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [15:0]      in_noise_0,
    input  logic signed [15:0]      in_noise_1,
    output logic                    core_start,
    output logic signed [15:0]      core_noise_0,
    output logic signed [15:0]      core_noise_1,
    input  logic                    core_done,
    input  logic [IMG_W-1:0]        core_image,
    input  logic signed [15:0]      core_prob,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IMG_W-1:0]        out_image,
    output logic signed [15:0]      out_prob,
    output logic [TAG_W-1:0]        out_tag,
    output logic                    out_real,
    output logic                    out_timeout,
    output logic                    busy,
    output logic [15:0]             sample_count,
    output logic [15:0]             real_count
);

    localparam int ENTRY_W = 2 * PIX_W + TAG_W;
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    sched_state_t        state_r;
    sched_state_t        state_next_s;
    logic                fifo_push_s;
    logic                fifo_pop_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [ENTRY_W-1:0]  fifo_head_s;
    logic                capture_s;
    logic                expire_s;
    logic                deliver_s;
    logic [TAG_W-1:0]    tag_cnt_r;
    logic [TAG_W-1:0]    tag_r;
    logic [WD_W-1:0]     wd_r;
    logic                core_start_r;
    logic signed [15:0]  noise0_r;
    logic signed [15:0]  noise1_r;
    logic                out_valid_r;
    logic [IMG_W-1:0]    image_r;
    logic signed [15:0]  prob_r;
    logic                out_real_r;
    logic                out_timeout_r;
    logic [15:0]         sample_cnt_r;
    logic [15:0]         real_cnt_r;

    // in_ready comes from the registered count only: a pop never frees a slot in the same cycle
    assign in_ready    = !fifo_full_s;
    assign fifo_push_s = in_valid && !fifo_full_s;

    gan_noise_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data ({in_noise_0, in_noise_1, tag_cnt_r}),
        .pop       (fifo_pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign core_start   = core_start_r;
    assign core_noise_0 = noise0_r;
    assign core_noise_1 = noise1_r;
    assign out_valid    = out_valid_r;
    assign out_image    = image_r;
    assign out_prob     = prob_r;
    assign out_tag      = tag_r;
    assign out_real     = out_real_r;
    assign out_timeout  = out_timeout_r;
    assign busy         = (state_r != IDLE) || !fifo_empty_s;
    assign sample_count = sample_cnt_r;
    assign real_count   = real_cnt_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state and per-cycle strobes; core_done beats watchdog expiry
    always_comb begin
        state_next_s = state_r;
        fifo_pop_s   = 1'b0;
        capture_s    = 1'b0;
        expire_s     = 1'b0;
        deliver_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    fifo_pop_s   = 1'b1;
                    state_next_s = LAUNCH;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LAUNCH: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    capture_s    = 1'b1;
                    state_next_s = HOLD;
                end else if (wd_r == WD_LAST) begin
                    expire_s     = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    state_next_s = WAIT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    deliver_s = 1'b1;
                    if (!fifo_empty_s) begin
                        fifo_pop_s   = 1'b1;
                        state_next_s = LAUNCH;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Tag counter advances on every accepted request and wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_cnt_r <= {TAG_W{1'b0}};
        end else if (fifo_push_s) begin
            tag_cnt_r <= tag_cnt_r + TAG_W'(1'b1);
        end
    end

    // Popped head entry drives the core and is held until the next pop
    always_ff @(posedge clk) begin
        if (rst) begin
            noise0_r <= 16'sd0;
            noise1_r <= 16'sd0;
            tag_r    <= {TAG_W{1'b0}};
        end else if (fifo_pop_s) begin
            noise0_r <= fifo_head_s[ENTRY_W-1 -: PIX_W];
            noise1_r <= fifo_head_s[TAG_W +: PIX_W];
            tag_r    <= fifo_head_s[TAG_W-1:0];
        end
    end

    // Start pulse mirrors the LAUNCH state; watchdog clears in LAUNCH, counts in WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            core_start_r <= 1'b0;
            wd_r         <= {WD_W{1'b0}};
        end else begin
            core_start_r <= (state_next_s == LAUNCH);
            if (state_r == LAUNCH) begin
                wd_r <= {WD_W{1'b0}};
            end else if (state_r == WAIT) begin
                wd_r <= wd_r + WD_W'(1'b1);
            end
        end
    end

    // Result capture; registers stay frozen for the whole HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            image_r       <= {IMG_W{1'b0}};
            prob_r        <= 16'sd0;
            out_real_r    <= 1'b0;
            out_timeout_r <= 1'b0;
        end else begin
            out_valid_r <= (state_next_s == HOLD);
            if (capture_s) begin
                image_r       <= core_image;
                prob_r        <= core_prob;
                out_real_r    <= (core_prob > Q15_HALF);
                out_timeout_r <= 1'b0;
            end else if (expire_s) begin
                image_r       <= {IMG_W{1'b0}};
                prob_r        <= 16'sd0;
                out_real_r    <= 1'b0;
                out_timeout_r <= 1'b1;
            end
        end
    end

    // Delivery counters, updated on the output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_cnt_r <= 16'd0;
            real_cnt_r   <= 16'd0;
        end else if (deliver_s) begin
            sample_cnt_r <= sat_inc16(sample_cnt_r);
            if (out_real_r && !out_timeout_r) begin
                real_cnt_r <= sat_inc16(real_cnt_r);
            end
        end
    end

endmodule

// File: tb/tb_gan_infer_scheduler.sv
// Self-checking bench for gan_infer_scheduler. A behavioural core model
// answers each core_start after a per-request delay (0 = never); expected
// results are queued when a request is accepted and compared when the
// scheduler hands a result over.
module tb_gan_infer_scheduler;

    localparam int TO = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_noise_0;
    logic [15:0]  in_noise_1;
    logic         core_start;
    logic [15:0]  core_noise_0;
    logic [15:0]  core_noise_1;
    logic         core_done;
    logic [143:0] core_image;
    logic [15:0]  core_prob;
    logic         out_valid;
    logic         out_ready;
    logic [143:0] out_image;
    logic [15:0]  out_prob;
    logic [3:0]   out_tag;
    logic         out_real;
    logic         out_timeout;
    logic         busy;
    logic [15:0]  sample_count;
    logic [15:0]  real_count;

    gan_infer_scheduler #(
        .FIFO_DEPTH     (4),
        .TAG_W          (4),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_noise_0   (in_noise_0),
        .in_noise_1   (in_noise_1),
        .core_start   (core_start),
        .core_noise_0 (core_noise_0),
        .core_noise_1 (core_noise_1),
        .core_done    (core_done),
        .core_image   (core_image),
        .core_prob    (core_prob),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_image    (out_image),
        .out_prob     (out_prob),
        .out_tag      (out_tag),
        .out_real     (out_real),
        .out_timeout  (out_timeout),
        .busy         (busy),
        .sample_count (sample_count),
        .real_count   (real_count)
    );

    typedef struct {
        logic [3:0]   tag;
        logic [143:0] img;
        logic [15:0]  prob;
        logic         is_real;
        logic         to;
    } exp_t;

    typedef struct {
        int          delay;
        logic [15:0] prob;
    } beh_t;

    exp_t        exp_q[$];
    beh_t        core_q[$];
    exp_t        mon_e;
    exp_t        in_e;
    beh_t        cm_b;
    int          cm_wait;
    logic        cm_busy;
    logic [15:0] cm_n0;
    logic [15:0] cm_n1;
    logic        stray_done;
    int          nx_delay;
    logic [15:0] nx_prob;
    logic [3:0]  m_tag;
    logic [15:0] m_samples;
    logic [15:0] m_reals;
    int          n_vec;
    int          n_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [143:0] img_of(input logic [15:0] a, input logic [15:0] b);
        logic [143:0] r;
        for (int i = 0; i < 9; i++) begin
            r[i*16 +: 16] = a ^ (b + 16'(i * 4369));
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        exp_q.delete();
        core_q.delete();
        cm_busy   = 1'b0;
        m_tag     = 4'd0;
        m_samples = 16'd0;
        m_reals   = 16'd0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input int dly,
                        input logic [15:0] p, output int waited);
        in_noise_0 = a;
        in_noise_1 = b;
        nx_delay   = dly;
        nx_prob    = p;
        in_valid   = 1'b1;
        waited     = 0;
        while (!in_ready && waited < 500) begin
            tick();
            waited++;
        end
        if (waited >= 500) begin
            check_eq("send_stall", in_ready, 1'b1);
            in_valid = 1'b0;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (core_start !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            tick();
            n++;
        end
        check_eq("drain", 144'(exp_q.size()), 144'd0);
        tick();
    endtask

    // Accepted request: record expected result and the core's behaviour for it
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            in_e.tag     = m_tag;
            m_tag        = m_tag + 4'd1;
            in_e.to      = (nx_delay == 0) || (nx_delay > TO);
            in_e.img     = in_e.to ? 144'd0 : img_of(in_noise_0, in_noise_1);
            in_e.prob    = in_e.to ? 16'd0 : nx_prob;
            in_e.is_real = !in_e.to && ($signed(nx_prob) > $signed(16'h4000));
            exp_q.push_back(in_e);
            core_q.push_back('{nx_delay, nx_prob});
        end
    end

    // Delivered result: compare against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", out_valid, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("sample_count", sample_count, m_samples);
                check_eq("real_count", real_count, m_reals);
                check_eq("out_tag", out_tag, mon_e.tag);
                check_eq("out_image", out_image, mon_e.img);
                check_eq("out_prob", out_prob, mon_e.prob);
                check_eq("out_real", out_real, mon_e.is_real);
                check_eq("out_timeout", out_timeout, mon_e.to);
                m_samples = m_samples + 16'd1;
                if (mon_e.is_real) m_reals = m_reals + 16'd1;
            end
        end
    end

    // Behavioural GAN core: done pulse 'delay' cycles after core_start
    initial begin
        core_done  = 1'b0;
        core_image = 144'd0;
        core_prob  = 16'd0;
        forever begin
            @(posedge clk);
            #2;
            core_done = 1'b0;
            if (stray_done) begin
                core_done  = 1'b1;
                core_prob  = 16'h7FFF;
                stray_done = 1'b0;
            end else if (core_start) begin
                if (core_q.size() > 0) begin
                    cm_b    = core_q.pop_front();
                    cm_wait = cm_b.delay;
                    cm_busy = (cm_wait != 0);
                    cm_n0   = core_noise_0;
                    cm_n1   = core_noise_1;
                end
            end else if (cm_busy) begin
                cm_wait--;
                if (cm_wait == 0) begin
                    core_done  = 1'b1;
                    core_image = img_of(cm_n0, cm_n1);
                    core_prob  = cm_b.prob;
                    cm_busy    = 1'b0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int n;
        n_vec      = 0;
        n_miss     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_noise_0 = 16'd0;
        in_noise_1 = 16'd0;
        out_ready  = 1'b0;
        stray_done = 1'b0;
        nx_delay   = 1;
        nx_prob    = 16'd0;
        cm_busy    = 1'b0;
        #1;
        do_reset(3);

        // Reset state
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_core_start", core_start, 1'b0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_real", out_real, 1'b0);
        check_eq("rst_out_timeout", out_timeout, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_out_tag", out_tag, 4'd0);
        check_eq("rst_out_image", out_image, 144'd0);
        check_eq("rst_out_prob", out_prob, 16'd0);
        check_eq("rst_core_noise", {core_noise_0, core_noise_1}, 32'd0);
        check_eq("rst_counts", {sample_count, real_count}, 32'd0);

        // Single request: latency, REAL classification
        out_ready = 1'b1;
        send(16'h4000, 16'h4000, 12, 16'h6000, w);
        wait_start(n);
        check_eq("start_latency", n, 32'd1);
        check_eq("core_noise", {core_noise_0, core_noise_1}, 32'h4000_4000);
        wait_valid(n);
        check_eq("done_to_valid", n, 32'd13);
        check_eq("single_tag", out_tag, 4'd0);
        check_eq("single_real", out_real, 1'b1);
        tick();
        check_eq("single_real_count", real_count, 16'd1);
        check_eq("single_sample_count", sample_count, 16'd1);
        check_eq("single_busy", busy, 1'b0);

        // core_done while IDLE is ignored
        stray_done = 1'b1;
        tick();
        tick();
        check_eq("stray_valid", out_valid, 1'b0);
        check_eq("stray_busy", busy, 1'b0);

        // Burst of 6 with consumer stalled
        do_reset(2);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(16'(16'h1000 + i), 16'(16'h0200 * i), 3, (i % 2 == 0) ? 16'h3000 : 16'h5000, w);
        end
        check_eq("burst_in_ready_low", in_ready, 1'b0);
        check_eq("burst_busy", busy, 1'b1);
        in_noise_0 = 16'h1005;
        in_noise_1 = 16'h0A00;
        nx_delay   = 3;
        nx_prob    = 16'h5000;
        in_valid   = 1'b1;
        repeat (5) tick();
        check_eq("burst_held_off", 144'(exp_q.size()), 144'd5);
        out_ready = 1'b1;
        tick();
        check_eq("b2b_start", core_start, 1'b1);
        check_eq("ready_after_pop", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_eq("burst_accepted", m_tag, 4'd6);
        drain();
        check_eq("burst_samples", sample_count, 16'd6);
        check_eq("burst_reals", real_count, m_reals);

        // Watchdog expiry with a silent core
        send(16'h1234, 16'h5678, 0, 16'h7000, w);
        wait_start(n);
        wait_valid(n);
        check_eq("timeout_latency", n, 32'(TO + 1));
        check_eq("timeout_flag", out_timeout, 1'b1);
        check_eq("timeout_image", out_image, 144'd0);
        check_eq("timeout_prob", out_prob, 16'd0);
        tick();
        check_eq("timeout_real_count", real_count, m_reals);

        // done coincident with expiry; threshold and sign boundaries
        send(16'h0F0F, 16'hF0F0, TO, 16'h4000, w);
        wait_start(n);
        wait_valid(n);
        check_eq("coinc_latency", n, 32'(TO + 1));
        check_eq("coinc_timeout", out_timeout, 1'b0);
        check_eq("coinc_real", out_real, 1'b0);
        tick();
        send(16'h0001, 16'h0002, 4, 16'h8000, w);
        send(16'h0003, 16'h0004, 4, 16'h4001, w);
        drain();
        check_eq("bound_reals", real_count, m_reals);
        check_eq("bound_samples", sample_count, 16'd10);

        // Reset while in WAIT with three requests queued
        for (int i = 0; i < 4; i++) begin
            send(16'(16'h2000 + i), 16'h0101, 0, 16'h6000, w);
        end
        check_eq("pre_rst_busy", busy, 1'b1);
        do_reset(1);
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        check_eq("post_rst_busy", busy, 1'b0);
        check_eq("post_rst_counts", {sample_count, real_count}, 32'd0);
        check_eq("post_rst_valid", out_valid, 1'b0);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (core_start) n++;
            tick();
        end
        check_eq("post_rst_no_start", n, 32'd0);

        // 17 requests: tag wraps back to 0 on the last one
        do_reset(2);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send(16'(16'h3000 + i * 7), 16'(16'h0040 * i), 2, (i % 3 == 0) ? 16'h4001 : 16'h3FFF, w);
        end
        drain();
        check_eq("wrap_samples", sample_count, 16'd17);
        check_eq("wrap_reals", real_count, m_reals);
        check_eq("wrap_last_tag", out_tag, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
